adder_32bit: RTL and testbench

ADDER_32BIT -- requirements
Module: adder_32bit

---
 rtl/adder_32bit.sv | 78 +++++++
 tb/tb_adder_32bit.sv | 139 +++++++++++++
 2 files changed

// File: rtl/adder_32bit.sv
// Registered 32-bit adder built from eight 4-bit carry-lookahead groups
// and a second-level lookahead unit that resolves every group carry in parallel.
module adder_32bit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic        c_in,
  output logic [31:0] sum,
  output logic        c_out
);

  logic [31:0] g;
  logic [31:0] p;
  logic [31:0] carry;
  logic [7:0]  grp_g;
  logic [7:0]  grp_p;
  logic [8:0]  grp_c;

  assign g = in1 & in2;
  assign p = in1 ^ in2;

  // First level: group generate/propagate and the carries inside each group
  for (genvar k = 0; k < 8; k++) begin : gen_group
    localparam int B = 4 * k;

    assign grp_g[k] = g[B+3]
                    | (p[B+3] & g[B+2])
                    | (p[B+3] & p[B+2] & g[B+1])
                    | (p[B+3] & p[B+2] & p[B+1] & g[B]);
    assign grp_p[k] = p[B+3] & p[B+2] & p[B+1] & p[B];

    assign carry[B]   = grp_c[k];
    assign carry[B+1] = g[B] | (p[B] & grp_c[k]);
    assign carry[B+2] = g[B+1]
                      | (p[B+1] & g[B])
                      | (p[B+1] & p[B] & grp_c[k]);
    assign carry[B+3] = g[B+2]
                      | (p[B+2] & g[B+1])
                      | (p[B+2] & p[B+1] & g[B])
                      | (p[B+2] & p[B+1] & p[B] & grp_c[k]);
  end

  // Second level: each group carry is a flat sum of products of c_in and
  // the group G/P terms, so no carry ripples from one group to the next.
  always_comb begin
    logic acc;
    logic prod;
    grp_c    = '0;
    grp_c[0] = c_in;
    for (int k = 0; k < 8; k++) begin
      acc = 1'b0;
      for (int j = 0; j <= k; j++) begin
        prod = grp_g[j];
        for (int m = j + 1; m <= k; m++) begin
          prod = prod & grp_p[m];
        end
        acc = acc | prod;
      end
      prod = c_in;
      for (int m = 0; m <= k; m++) begin
        prod = prod & grp_p[m];
      end
      grp_c[k+1] = acc | prod;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum   <= '0;
      c_out <= 1'b0;
    end else begin
      sum   <= p ^ carry;
      c_out <= grp_c[8];
    end
  end

endmodule

// File: tb/tb_adder_32bit.sv
// Self-checking bench for adder_32bit: directed corner cases, hold/reset
// timing and random vectors against a plain 33-bit arithmetic model.
module tb_adder_32bit;

  logic        clk;
  logic        rst_n;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        c_in;
  logic [31:0] sum;
  logic        c_out;

  int checks;
  int failures;

  adder_32bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .in1   (in1),
    .in2   (in2),
    .c_in  (c_in),
    .sum   (sum),
    .c_out (c_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [32:0] refAdd(input logic [31:0] a, input logic [31:0] b,
                                         input logic c);
    return {1'b0, a} + {1'b0, b} + {32'd0, c};
  endfunction

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic c);
    in1  = a;
    in2  = b;
    c_in = c;
  endtask

  task automatic checkOutput(input string tag, input logic [32:0] expected);
    checks++;
    assert ({c_out, sum} === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s: got c_out=%b sum=%h, expected c_out=%b sum=%h",
             tag, c_out, sum, expected[32], expected[31:0]);
    end
  endtask

  task automatic runVector(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic c);
    @(negedge clk);
    applyStimulus(a, b, c);
    @(posedge clk);
    #1;
    checkOutput(tag, refAdd(a, b, c));
  endtask

  initial begin
    logic [32:0] held;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rc;
    checks   = 0;
    failures = 0;

    rst_n = 1'b1;
    applyStimulus($urandom, $urandom, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("reset_async", 33'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_held", 33'd0);

    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(32'h0, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("post_reset_zero", 33'd0);

    runVector("signed_neg",      32'hFFFFFFE0, 32'hFFFFFFF5, 1'b0);
    checkOutput("signed_neg_lit", {1'b1, 32'hFFFFFFD5});
    runVector("full_propagate",  32'hFFFFFFFF, 32'h00000000, 1'b1);
    checkOutput("full_prop_lit", {1'b1, 32'h00000000});
    runVector("max_pos_plus1",   32'h7FFFFFFF, 32'h00000001, 1'b0);
    checkOutput("max_pos_lit",   {1'b0, 32'h80000000});
    runVector("group0_boundary", 32'h0000000F, 32'h00000001, 1'b0);
    runVector("group6_boundary", 32'h0FFFFFFF, 32'h00000001, 1'b0);
    checkOutput("group6_lit",    {1'b0, 32'h10000000});
    runVector("all_ones_cin",    32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    runVector("alt_pattern",     32'hAAAAAAAA, 32'h55555555, 1'b1);
    for (int k = 1; k < 8; k++) begin
      runVector("group_edge", (32'h1 << (4 * k)) - 32'h1, 32'h1, 1'b0);
    end

    // Outputs must not follow input changes between rising edges
    runVector("pre_hold", 32'h12345678, 32'h11111111, 1'b0);
    held = refAdd(32'h12345678, 32'h11111111, 1'b0);
    applyStimulus(32'hDEADBEEF, 32'hCAFEF00D, 1'b1);
    #2;
    checkOutput("hold_mid", held);
    @(negedge clk);
    checkOutput("hold_negedge", held);
    @(posedge clk);
    #1;
    checkOutput("hold_next_edge", refAdd(32'hDEADBEEF, 32'hCAFEF00D, 1'b1));

    // Reset dropped between edges clears the outputs at once
    applyStimulus(32'h0F0F0F0F, 32'hF0F0F0F0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("reset_mid", 33'd0);
    @(posedge clk);
    #1;
    checkOutput("reset_mid_held", 33'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(32'h80000000, 32'h80000000, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("post_reset_first", refAdd(32'h80000000, 32'h80000000, 1'b1));

    for (int i = 0; i < 10000; i++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(1, 0));
      runVector("random", ra, rb, rc);
    end

    $display("[TB] directed and random checks complete");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
